// File: rtl/phase_reload_ctrl.sv
// Phase sequencer for a 4-bit preset down-counter: presents each phase's preset, pulses botao, reloads on Q==0.
// Latency: botao rises 2 cycles after start; 3-cycle reload overhead per phase. No backpressure; stop aborts to IDLE.
// Optional WATCHDOG_EN: WD_LIMIT RUN cycles without Q==0 set a sticky fault and reload the same phase.
module phase_reload_ctrl #(
    parameter int         NUM_PHASES = 3,
    parameter logic [3:0] PRESET0    = 4'd9,
    parameter logic [3:0] PRESET1    = 4'd3,
    parameter logic [3:0] PRESET2    = 4'd7,
    parameter logic [3:0] PRESET3    = 4'd5,
    parameter int         WD_LIMIT   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] Q,
    output logic [3:0] preset,
    output logic       botao,
    output logic [1:0] phase,
    output logic       phase_done,
    output logic       running,
    output logic       fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);

    logic [2:0] r_state;
    logic [1:0] r_phase;
    logic [3:0] r_preset;
    logic       r_botao;
    logic       r_phase_done;
    logic       r_running;

    logic [2:0] w_state_nxt;
    logic [1:0] w_phase_inc;
    logic       w_zero;
    logic       w_begin;
    logic       w_advance;
    logic       w_wd_expire;

    function automatic logic [3:0] preset_of(input logic [1:0] idx);
        logic [3:0] v;
        case (idx)
            2'd0:    v = PRESET0;
            2'd1:    v = PRESET1;
            2'd2:    v = PRESET2;
            default: v = PRESET3;
        endcase
        return v;
    endfunction

    assign w_zero      = (Q == 4'b0000);
    assign w_phase_inc = (r_phase == LAST_PHASE) ? 2'd0 : r_phase + 2'd1;
    assign w_begin     = !stop && (r_state == S_IDLE) && start;

    // stop outranks start, terminal count and the watchdog
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_state_nxt = S_SETUP;
                S_SETUP:  w_state_nxt = S_LOAD;
                S_LOAD:   w_state_nxt = S_SETTLE;
                S_SETTLE: w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_zero) begin
                        w_state_nxt = S_SETUP;
                        w_advance   = 1'b1;
                    end else if (w_wd_expire) begin
                        w_state_nxt = S_SETUP;
                    end
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // botao is decoded from the next state so the pin itself is a flop output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase      <= 2'd0;
            r_preset     <= PRESET0;
            r_botao      <= 1'b0;
            r_phase_done <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_botao      <= (w_state_nxt == S_LOAD);
            r_phase_done <= w_advance;
            r_running    <= (w_state_nxt != S_IDLE);
            if (w_begin) begin
                r_phase  <= 2'd0;
                r_preset <= PRESET0;
            end else if (w_advance) begin
                r_phase  <= w_phase_inc;
                r_preset <= preset_of(w_phase_inc);
            end
        end
    end

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_fault;

    assign w_wd_expire = (r_wd_cnt == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state != S_RUN) begin
                r_wd_cnt <= '0;
            end else if (!w_zero) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if ((r_state == S_RUN) && !stop && !w_zero && w_wd_expire) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault = r_fault;
`else
    assign w_wd_expire = 1'b0;
    assign fault       = 1'b0;
`endif

    assign preset     = r_preset;
    assign botao      = r_botao;
    assign phase      = r_phase;
    assign phase_done = r_phase_done;
    assign running    = r_running;

    a_botao_single: assert property (@(posedge clock) disable iff (reset) botao |=> !botao);
    a_phase_range:  assert property (@(posedge clock) disable iff (reset) int'(phase) < NUM_PHASES);

endmodule
